day6_mac_accumulator: RTL

Multiply-accumulate back end for the 4-bit multiplier. It consumes the multiplier's 8-bit products over a valid/ready handshake and sums NUM_TERMS of them into a wider accumulator. It presents the finished dot-product sum downstream on a second valid/ready handshake and holds it until that handshake completes. It sits directly downstream of day5_4bit_multiplier.

---
 rtl/day6_mac_accumulator.sv | 126 ++++++++++++
 1 files changed

// File: rtl/day6_mac_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : day6_mac_accumulator
// Summary  : Multiply-accumulate back end for the 4-bit multiplier. Sums
//            NUM_TERMS unsigned products received over a valid/ready
//            handshake and presents the result on a second valid/ready
//            handshake, holding it until downstream accepts it.
// Options  : MAC_SATURATE_EN - when defined, the accumulator clamps to
//            all-ones on carry-out instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
module day6_mac_accumulator #(
    parameter int PROD_W    = 8,
    parameter int ACC_W     = 12,
    parameter int NUM_TERMS = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         prod_valid,
    output logic                         prod_ready,
    input  logic [PROD_W-1:0]            product,
    output logic                         acc_valid,
    input  logic                         acc_ready,
    output logic [ACC_W-1:0]             acc_out,
    output logic [$clog2(NUM_TERMS):0]   term_cnt,
    output logic                         overflow
);

    localparam int                 c_cnt_w    = $clog2(NUM_TERMS) + 1;
    localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(NUM_TERMS - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [ACC_W-1:0]      acc_q, acc_d;
    logic [c_cnt_w-1:0]    cnt_q, cnt_d;
    logic                  ovf_q, ovf_d;
    logic                  prod_ready_q, prod_ready_d;
    logic                  acc_valid_q, acc_valid_d;
    logic [ACC_W:0]        add_sum;

    // Next-state logic: clear dominates both handshakes; handshakes are
    // qualified by the registered ready/valid so inputs never reach outputs.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        // One extra bit captures the carry-out used for overflow detection.
        add_sum  = {1'b0, acc_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, product};

        if (clear) begin
            state_d = ACCUM;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (prod_valid && prod_ready_q) begin
                        acc_d = add_sum[ACC_W-1:0];
                        if (add_sum[ACC_W]) begin
                            ovf_d = 1'b1;
`ifdef MAC_SATURATE_EN
                            acc_d = '1;
`else
                            acc_d = add_sum[ACC_W-1:0];
`endif
                        end
                        cnt_d = cnt_q + c_cnt_one;
                        if (cnt_q == c_last_cnt) begin
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    if (acc_ready && acc_valid_q) begin
                        state_d = ACCUM;
                        acc_d   = '0;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                    end
                end
                default: begin
                    state_d = ACCUM;
                end
            endcase
        end

        // Handshake outputs follow the next state so they are plain flops.
        prod_ready_d = (state_d == ACCUM);
        acc_valid_d  = (state_d == DONE);
    end

    // State and output registers; reset acts immediately, not on the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ACCUM;
            acc_q        <= '0;
            cnt_q        <= '0;
            ovf_q        <= 1'b0;
            prod_ready_q <= 1'b1;
            acc_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            ovf_q        <= ovf_d;
            prod_ready_q <= prod_ready_d;
            acc_valid_q  <= acc_valid_d;
        end
    end

    assign prod_ready = prod_ready_q;
    assign acc_valid  = acc_valid_q;
    assign acc_out    = acc_q;
    assign term_cnt   = cnt_q;
    assign overflow   = ovf_q;

endmodule
`default_nettype wire
